// File: rtl/shift_reg_scheduler_pkg.sv
// Shared types and helpers for the shift-register scheduler.
package shift_sched_pkg;

   // Scheduler FSM states, in the order a job visits them.
   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShift,
      StDone,
      StCapt,
      StResp
   } state_t;

   // Width of a shift-amount field able to hold 0..width.
   function automatic int unsigned amt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

   // Width of a requester id; never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   // Amounts beyond the register width would only keep shifting zeros in.
   function automatic int unsigned clamp_amt(input int unsigned amt, input int unsigned width);
      return (amt > width) ? width : amt;
   endfunction

endpackage

// File: rtl/shift_reg_scheduler_if.sv
// Request/response channel between client logic and the scheduler.
interface shift_reg_scheduler_if
   import shift_sched_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 2
) ();

   localparam int unsigned CW  = amt_width(WIDTH);
   localparam int unsigned IDW = id_width(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ*CW-1:0]    req_amt;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_data;

   // Client side.
   modport master (
      output req_valid, req_data, req_amt, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

   // Scheduler side.
   modport slave (
      input  req_valid, req_data, req_amt, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );

endinterface

// File: rtl/shift_reg_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted requester.
module rr_arbiter
   import shift_sched_pkg::*;
#(
   parameter  int unsigned NREQ = 2,
   localparam int unsigned IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  last_grant,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  id
);

   logic [IDW-1:0] idx;
   logic           found;

   // Pick the first valid requester after last_grant, wrapping modulo NREQ.
   always_comb begin
      grant = '0;
      id    = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         idx = IDW'((32'(last_grant) + off) % NREQ);
         if (!found && valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            id         = idx;
         end
      end
   end

endmodule

// File: rtl/shift_reg_scheduler.sv
// Shares one left-shift register among NREQ requesters, one job at a time.
module shift_reg_scheduler
   import shift_sched_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   shift_reg_scheduler_if.slave bus,
   output logic                 sr_load,
   output logic                 sr_shift,
   output logic                 sr_done,
   output logic [WIDTH-1:0]     sr_data_in,
   input  logic [WIDTH-1:0]     sr_data_out,
   output logic                 busy
);

   localparam int unsigned CW  = amt_width(WIDTH);
   localparam int unsigned IDW = id_width(NREQ);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_valid_q;

   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   arb_id;
   logic             accept;

   logic [WIDTH-1:0] data_arr [NREQ];
   logic [CW-1:0]    amt_arr  [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign data_arr[i] = bus.req_data[i*WIDTH +: WIDTH];
      assign amt_arr[i]  = bus.req_amt[i*CW +: CW];
   end

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_arb (
      .valid      (bus.req_valid),
      .last_grant (last_q),
      .grant      (grant),
      .id         (arb_id)
   );

   // Grants are only visible while idle; the grant already implies req_valid.
   assign bus.req_ready = (state_q == StIdle) ? grant : '0;
   assign accept        = (state_q == StIdle) && (|grant);

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign sr_data_in    = data_q;

   // Next-state logic: sequence load, shifts, done, capture, then respond.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      id_d       = id_q;
      last_d     = last_q;
      rsp_data_d = rsp_data_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               data_d  = data_arr[arb_id];
               cnt_d   = CW'(clamp_amt(32'(amt_arr[arb_id]), WIDTH));
               id_d    = arb_id;
               last_d  = arb_id;
               state_d = StLoad;
            end
         end
         StLoad: begin
            state_d = (cnt_q == '0) ? StDone : StShift;
         end
         StShift: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StCapt;
         end
         StCapt: begin
            // The register presents its result only in the cycle after the done strobe.
            rsp_data_d = sr_data_out;
            state_d    = StResp;
         end
         StResp: begin
            if (bus.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Job latches, shift counter and round-robin pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         data_q     <= '0;
         id_q       <= '0;
         last_q     <= IDW'(NREQ - 1);
         rsp_data_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         id_q       <= id_d;
         last_q     <= last_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   // Strobes and status decoded from the next state so they leave a flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_load     <= 1'b0;
         sr_shift    <= 1'b0;
         sr_done     <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy        <= 1'b0;
      end else begin
         sr_load     <= (state_d == StLoad);
         sr_shift    <= (state_d == StShift);
         sr_done     <= (state_d == StDone);
         rsp_valid_q <= (state_d == StResp);
         busy        <= (state_d != StIdle);
      end
   end

endmodule

// File: doc/shift_reg_scheduler.md
# shift_reg_scheduler

Round-robin scheduler that shares one `Param_shift_register`-style left-shift datapath among NREQ requesters. Each job supplies a word and a shift amount. The scheduler arbitrates, then drives the register's load, shift and done strobes for the right number of cycles. It captures the one-cycle `data_out` result and returns it over a valid/ready response channel tagged with the requester id. It sits between client logic and a single shared shift-register instance.

## Interface
- `WIDTH`, 8: data width; must match the shared register.
- `NREQ`, 2: number of requesters, range 2..8.
- `CW`, $clog2(WIDTH+1): width of shift-amount field.
- `IDW`, $clog2(NREQ): width of requester id.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in NREQ: per-requester job valid.
- `req_data` in NREQ*WIDTH: packed job words; slice i belongs to requester i.
- `req_amt` in NREQ*CW: packed shift amounts; slice i belongs to requester i.
- `req_ready` out NREQ: one-hot grant; a job is accepted when `req_valid[i] & req_ready[i]` is high at an edge.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_id` out IDW: id of the requester that owns the result.
- `rsp_data` out WIDTH: shifted result.
- `sr_load` out 1: load strobe to the shift register.
- `sr_shift` out 1: shift strobe.
- `sr_done` out 1: output-enable strobe.
- `sr_data_in` out WIDTH: word to load.
- `sr_data_out` in WIDTH: register output, valid only in the cycle after `sr_done`.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states are IDLE, LOAD, SHIFT, DONE, CAPT and RESP.
- **IDLE**
  - The arbiter raises at most one `req_ready` bit, combinationally, for the highest-priority valid requester.
  - On acceptance, latch data, the clamped amount and the id. Go to LOAD.
- **LOAD**
  - `sr_load=1` for one cycle.
  - If the amount is 0, go to DONE; otherwise go to SHIFT.
- **SHIFT**
  - `sr_shift=1` every cycle; the counter decrements each cycle.
  - Leave for DONE after exactly `amt` SHIFT cycles.
- **DONE**: `sr_done=1` for one cycle, then go to CAPT.
- **CAPT**: latch `sr_data_out` into `rsp_data`, then go to RESP.
- **RESP**
  - `rsp_valid=1`; `rsp_data` and `rsp_id` are held stable.
  - When `rsp_valid & rsp_ready` is high at an edge, go to IDLE.
- **Amount clamp:** `req_amt > WIDTH` saturates to WIDTH, so the result is all zeros after WIDTH shift cycles.
- **Round-robin arbitration**
  - The search starts at (last_grant+1) mod NREQ.
  - last_grant updates only on acceptance.
  - Reset sets last_grant to NREQ-1, so requester 0 has first priority.
- **Strobe exclusivity:** `sr_load`, `sr_shift` and `sr_done` are mutually exclusive. All three are 0 in IDLE, CAPT and RESP.
- **`sr_data_in`:** carries the latched job word in every state, and 0 after reset.
- **No new grants** are issued outside IDLE; `req_ready` is all 0 then.
- **Requester behaviour:** a requester may drop `req_valid` without handshake. The arbiter re-evaluates every IDLE cycle.
- **Reset mid-operation:** FSM returns to IDLE, counter and latches clear, and any in-flight job is lost. The shared register is reset by the same net.
- **Reset values:** `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `sr_load=0`, `sr_shift=0`, `sr_done=0`, `sr_data_in=0`, `busy=0`.

## Timing
- The accept edge is E0.
- LOAD occupies cycle 1 and SHIFT occupies cycles 2..amt+1.
- DONE occurs in cycle amt+2 and CAPT in cycle amt+3.
- `rsp_valid` rises in cycle amt+4. Minimum latency is 4 cycles (amt=0); maximum is WIDTH+4.
- The earliest next acceptance is the cycle after the response handshake, so throughput is one job per amt+5 cycles with `rsp_ready` held high.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.

## Structure
- Package `shift_sched_pkg` holds:
  - the state enum (IDLE, LOAD, SHIFT, DONE, CAPT, RESP);
  - function `clamp_amt`;
  - localparam helpers for CW and IDW.
- Sub-module `rr_arbiter` (parameter NREQ) takes valid and last_grant, and returns a one-hot grant plus the encoded id.

## Test plan
- Reset released, requester 0 sends `req_data=0xA5` with amt=4 → `sr_load` in cycle 1, `sr_shift` in cycles 2–5, `sr_done` in cycle 6. `rsp_valid` in cycle 8 with `rsp_data=0x50`, `rsp_id=0`.
- amt=0 with data 0x3C → no `sr_shift` pulses; `rsp_data=0x3C` in cycle 4.
- amt=15 with data 0xFF (WIDTH=8) → exactly 8 `sr_shift` cycles; `rsp_data=0x00`.
- Both requesters valid continuously, `rsp_ready=1` → grants alternate 0,1,0,1 and ids match grants.
- `rsp_ready` held low for 5 cycles → `rsp_valid`, `rsp_data` and `rsp_id` remain stable; `req_ready` stays all 0 and `busy=1`.
- `reset` asserted during SHIFT → all outputs read 0 immediately. After release, the next job completes normally with requester 0 prioritized.
